// File: rtl/uart_mmio_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: serializer state
// encoding, register offsets and STATUS bit positions.
package uart_mmio_tx_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [3:0] REG_STATUS = 4'h8;
   localparam logic [3:0] REG_TXDATA = 4'hC;

   localparam int unsigned STAT_READY = 0;
   localparam int unsigned STAT_BUSY  = 1;
   localparam int unsigned STAT_EMPTY = 2;
   localparam int unsigned STAT_OVF   = 3;

   // Line level for a given serializer state; data bits come from the shifter LSB.
   function automatic logic tx_level(input logic [1:0] state, input logic shift_lsb);
      logic level;
      case (state)
         ST_START: level = 1'b0;
         ST_DATA:  level = shift_lsb;
         default:  level = 1'b1;
      endcase
      return level;
   endfunction

endpackage

// File: rtl/uart_mmio_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   assign full     = (count_q == CNT_FULL);
   assign empty    = (count_q == {(AW+1){1'b0}});
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      pop_ok_s  = pop && !empty;
      push_ok_s = push && (!full || pop_ok_s);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_mmio_tx.sv
// Memory-mapped UART transmitter: 16-byte register window, TX FIFO and an
// 8N1 serializer clocked by a CLK_DIV-cycle baud counter.
module uart_mmio_tx
   import uart_mmio_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rena,
   input  logic        wena,
   input  logic [1:0]  select,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        tx
);

   localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

   logic [1:0]    state_q, state_d;
   logic [15:0]   baud_q, baud_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          ovf_q, ovf_d;

   logic          wr_txdata_s, wr_status_s, ovf_evt_s, bit_end_s;
   logic [31:0]   status_s;
   logic          fifo_pop_s, fifo_full_s, fifo_empty_s;
   logic [7:0]    fifo_head_s;
   logic [CW-1:0] fifo_count_s;
   logic          unused_s;

   assign unused_s = ^{select, wdata[31:8], fifo_count_s};
   assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
   assign tx       = tx_q;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .push      (wr_txdata_s),
      .push_data (wdata[7:0]),
      .pop       (fifo_pop_s),
      .pop_data  (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   // Register decode and combinational read mux; size is ignored.
   always_comb begin
      wr_txdata_s          = 1'b0;
      wr_status_s          = 1'b0;
      rdata                = 32'h0;
      status_s             = 32'h0;
      status_s[STAT_READY] = ~fifo_full_s;
      status_s[STAT_BUSY]  = (state_q != ST_IDLE);
      status_s[STAT_EMPTY] = fifo_empty_s;
      status_s[STAT_OVF]   = ovf_q;
      if (hit) begin
         wr_txdata_s = wena && (addr[3:0] == REG_TXDATA);
         wr_status_s = wena && (addr[3:0] == REG_STATUS);
         if (rena && (addr[3:0] == REG_STATUS)) begin
            rdata = status_s;
         end else begin
            rdata = 32'h0;
         end
      end else begin
         rdata = 32'h0;
      end
   end

   // Sticky overflow: a discarded byte beats a simultaneous clear.
   always_comb begin
      ovf_evt_s = wr_txdata_s && fifo_full_s && !fifo_pop_s;
      if (ovf_evt_s) begin
         ovf_d = 1'b1;
      end else if (wr_status_s && wdata[STAT_OVF]) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Serializer FSM with baud counter; tx is registered from the next state.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      fifo_pop_s = 1'b0;
      bit_end_s  = (baud_q == BAUD_LAST);
      case (state_q)
         ST_IDLE: begin
            baud_d = 16'd0;
            if (!fifo_empty_s) begin
               fifo_pop_s = 1'b1;
               shift_d    = fifo_head_s;
               bit_cnt_d  = 3'd0;
               state_d    = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               baud_d  = 16'd0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               baud_d = 16'd0;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               baud_d  = 16'd0;
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            baud_d  = 16'd0;
            state_d = ST_IDLE;
         end
      endcase
      tx_d = tx_level(state_d, shift_d[0]);
   end

   // Control state registers; reset abandons any frame and idles the line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         baud_q    <= 16'd0;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'd0;
         tx_q      <= 1'b1;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Self-checking bench for uart_mmio_tx: directed scenarios plus random bus
// traffic, compared every cycle against a queue/frame-based reference model.
module tb_uart_mmio_tx;

   localparam int          DIV   = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
   localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rena = 1'b0, wena = 1'b0;
   logic [1:0]  select = 2'd0;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic        hit, tx;
   logic [31:0] rdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uart_mmio_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .rena(rena), .wena(wena), .select(select),
      .addr(addr), .wdata(wdata), .hit(hit), .rdata(rdata), .tx(tx)
   );

   // Reference model: pending bytes, and the 10-bit frame on the wire indexed by elapsed time.
   logic [7:0] mq[$];
   bit         m_active = 1'b0;
   logic [9:0] m_frame  = 10'h3FF;
   int         m_t      = 0;
   bit         m_ovf    = 1'b0;

   function automatic logic [31:0] m_status();
      return {28'h0, m_ovf, (mq.size() == 0), m_active, (mq.size() < DEPTH)};
   endfunction

   function automatic logic m_tx();
      return m_active ? m_frame[m_t / DIV] : 1'b1;
   endfunction

   function automatic logic [31:0] m_reg(input logic [31:0] a);
      if (a[31:4] != BASE[31:4]) return 32'h0;
      if (a[3:0] == 4'h8) return m_status();
      return 32'h0;
   endfunction

   task automatic m_reset();
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
   endtask

   task automatic m_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
      bit pop, in_win, ovf_evt;
      logic [7:0] b;
      pop     = !m_active && (mq.size() > 0);
      in_win  = (a[31:4] == BASE[31:4]);
      ovf_evt = 1'b0;
      if (m_active) begin
         m_t++;
         if (m_t == 10 * DIV) m_active = 1'b0;
      end
      if (pop) begin
         b        = mq.pop_front();
         m_frame  = {1'b1, b, 1'b0};
         m_active = 1'b1;
         m_t      = 0;
      end
      if (w && in_win && a[3:0] == 4'hC) begin
         if (mq.size() < DEPTH) mq.push_back(d[7:0]);
         else ovf_evt = 1'b1;
      end
      if (ovf_evt) m_ovf = 1'b1;
      else if (w && in_win && a[3:0] == 4'h8 && d[3]) m_ovf = 1'b0;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // One bus cycle: drive at the falling edge, check comb outputs, step model, check tx.
   task automatic apply(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      rena   = r;
      wena   = w;
      addr   = a;
      wdata  = d;
      select = 2'($urandom_range(0, 3));
      #1;
      check_eq("hit", {31'h0, hit}, {31'h0, (a[31:4] == BASE[31:4])});
      check_eq("rdata", rdata, r ? m_reg(a) : 32'h0);
      m_edge(w, a, d);
      @(posedge clk);
      #1;
      rena = 1'b0;
      wena = 1'b0;
      @(negedge clk);
      check_eq("tx", {31'h0, tx}, {31'h0, m_tx()});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((m_active || mq.size() > 0) && guard < 600) begin
         apply(1'b0, 1'b0, 32'h0, 32'h0);
         guard++;
      end
      if (guard >= 600) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: model still busy after %0d cycles", guard);
      end
      idle(2);
   endtask

   task automatic reset_mid_cycle();
      #2;
      rst = 1'b0;
      #1;
      check_eq("rst_tx", {31'h0, tx}, 32'h1);
      m_reset();
      @(negedge clk);
      check_eq("rst_hold_tx", {31'h0, tx}, 32'h1);
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] a, d;
      int r, guard;

      #3 rst = 1'b0;
      m_reset();
      @(negedge clk);
      #1 check_eq("reset_tx", {31'h0, tx}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      apply(1'b1, 1'b0, A_STATUS, 32'h0);

      // Single byte 0xA5 and idle status afterwards.
      apply(1'b0, 1'b1, A_TXDATA, 32'h0000_00A5);
      idle(45);
      apply(1'b1, 1'b0, A_STATUS, 32'h0);

      // Five back-to-back writes with the FIFO emptying one into the serializer.
      for (int i = 1; i <= 5; i++) apply(1'b0, 1'b1, A_TXDATA, 32'(i));
      apply(1'b1, 1'b0, A_STATUS, 32'h0);
      drain();
      apply(1'b1, 1'b0, A_STATUS, 32'h0);

      // Overflow while busy, then write-1-to-clear.
      for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, A_TXDATA, 32'h11 * (i + 1));
      apply(1'b0, 1'b1, A_TXDATA, 32'hFFFF_FF66);
      apply(1'b1, 1'b0, A_STATUS, 32'h0);
      apply(1'b0, 1'b1, A_STATUS, 32'h0000_0008);
      apply(1'b1, 1'b0, A_STATUS, 32'h0);

      // Push into a full FIFO on the same edge the serializer pops.
      guard = 0;
      while (m_active && guard < 100) begin
         apply(1'b0, 1'b0, 32'h0, 32'h0);
         guard++;
      end
      apply(1'b0, 1'b1, A_TXDATA, 32'h0000_0077);
      apply(1'b1, 1'b0, A_STATUS, 32'h0);
      drain();

      // Reset in the middle of the data bits of 0xFF.
      apply(1'b0, 1'b1, A_TXDATA, 32'h0000_00FF);
      idle(10);
      reset_mid_cycle();
      apply(1'b1, 1'b0, A_STATUS, 32'h0);
      idle(50);

      // Out-of-window and reserved-offset reads.
      apply(1'b1, 1'b0, 32'h1001_0000, 32'h0);
      apply(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
      apply(1'b1, 1'b0, 32'hFFFF_0000, 32'h0);
      apply(1'b1, 1'b0, A_TXDATA, 32'h0);
      apply(1'b0, 1'b1, 32'h1001_000C, 32'h0000_0042);

      // Random bus traffic.
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         d = $urandom;
         if ($urandom_range(0, 3) == 0) a = $urandom;
         else a = {BASE[31:4], 2'($urandom_range(0, 3)), 2'b00};
         if (r < 6) apply(1'b0, 1'b1, A_TXDATA, d);
         else if (r < 9) apply(1'b0, 1'b1, A_STATUS, d);
         else if (r < 12) apply(1'b0, 1'b1, a, d);
         else if (r < 30) apply(1'b1, 1'b0, a, d);
         else apply(1'b0, 1'b0, a, d);
      end
      drain();
      apply(1'b1, 1'b0, A_STATUS, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
